regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port (write_enable/rd/rd_din) between
//  two writeback producers: port A (ALU/EX) and port B (load/MEM).
//  Each port has a DEPTH-entry FIFO; a round-robin arbiter drains one entry per
//  cycle into a registered write stage that drives the register file.
//  pending_mask gives decode/hazard logic a per-register "write outstanding" view.
// PARAMETERS
//  DEPTH  4  entries per port FIFO; power of two, >=2
// PORTS
//  clk           in   1   clock
//  reset         in   1   synchronous, active-high reset
//  a_valid       in   1   port A write request valid
//  a_ready       out  1   port A can accept (FIFO A count < DEPTH)
//  a_rd          in   5   port A destination register
//  a_data        in   32  port A write data
//  b_valid       in   1   port B write request valid
//  b_ready       out  1   port B can accept (FIFO B count < DEPTH)
//  b_rd          in   5   port B destination register
//  b_data        in   32  port B write data
//  rf_we         out  1   to register file write_enable
//  rf_rd         out  5   to register file rd
//  rf_din        out  32  to register file rd_din
//  pending_mask  out  32  bit r=1: a write to xr is queued or in the write stage
//  idle          out  1   both FIFOs empty and rf_we==0
// BEHAVIOUR
//  Reset: synchronous, active-high, on clk. Reset clears both FIFOs (pointers and counts = 0)
//   and the write stage. After reset: rf_we=0, rf_rd=0, rf_din=0,
//   pending_mask=0, idle=1, a_ready=b_ready=1, last_grant=B.
//   Reset mid-operation discards every queued entry; no rf_we pulse follows it.
//  Accept: handshake = valid && ready at posedge. ready = count<DEPTH only;
//   a pop in the same cycle does not make a full FIFO ready (no pass-through).
//   Data/rd are sampled only on the accepting edge; valid may drop anytime.
//  x0: accepted request with rd==0 is consumed (ready honoured) but not
//   enqueued; it never sets pending_mask and never produces rf_we.
//  Arbitration (combinational on FIFO heads, every cycle):
//   only A nonempty -> grant A; only B nonempty -> grant B;
//   both nonempty -> grant the port != last_grant; neither -> no grant.
//   last_grant updates only when a grant occurs.
//  Pop/write stage: granted head popped at posedge; same edge loads
//   rf_we=1, rf_rd, rf_din. No grant -> rf_we=0 (rf_rd/rf_din hold).
//   Register file commits at the following posedge.
//  Latency: request accepted at edge E into empty FIFO, no contention ->
//   popped at E+1, rf_we high in cycle after E+1, regfile updated at E+2.
//  Throughput: one write per cycle total; alternates A/B under contention,
//   so neither port waits more than one grant behind the other.
//  Ordering: FIFO order preserved per port. No ordering between ports:
//   upstream must stall issue of a producer whose rd has pending_mask set.
//  pending_mask: combinational OR of one-hot(rd) over all valid FIFO entries
//   plus one-hot(rf_rd) when rf_we=1; bit 0 always 0.
//  Width rules: counts are log2(DEPTH)+1 bits; pointers log2(DEPTH) bits
//   and wrap modulo DEPTH.
//  Simultaneous push+pop on a port: count unchanged, both pointers advance.
// TESTING
//  1 Reset, then A push rd=5 data=0x11 -> rf_we=1, rf_rd=5, rf_din=0x11 two edges later; pending_mask[5] set until the edge after that write.
//  2 A and B both push every cycle (A rd=1.., B rd=9..) -> rf_we=1 every cycle, grants strictly A,B,A,B starting with A.
//  3 Stall drain: A pushes 4 entries with no pops -> a_ready=0 after 4th; 5th a_valid held, accepted only once a pop frees space; FIFO order intact across wrap.
//  4 B push rd=0 data=0xDEAD -> b_ready=1, no rf_we, pending_mask stays 0, idle stays 1.
//  5 A queue 3 entries, assert reset mid-drain -> rf_we=0 from next cycle, pending_mask=0, idle=1; no queued entry is ever written.
//  6 Scoreboard check: A rd=7, B rd=12 queued -> pending_mask=0x00001080; clears bit by bit as each is written.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Two-port writeback arbiter: per-port FIFOs drained round-robin, one entry per
// cycle, into a registered register-file write stage with a pending-write mask.
module regfile_wb_arbiter #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        a_valid,
   output logic        a_ready,
   input  logic [4:0]  a_rd,
   input  logic [31:0] a_data,
   input  logic        b_valid,
   output logic        b_ready,
   input  logic [4:0]  b_rd,
   input  logic [31:0] b_data,
   output logic        rf_we,
   output logic [4:0]  rf_rd,
   output logic [31:0] rf_din,
   output logic [31:0] pending_mask,
   output logic        idle
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [4:0]    a_rd_q   [DEPTH];
   logic [31:0]   a_data_q [DEPTH];
   logic [4:0]    b_rd_q   [DEPTH];
   logic [31:0]   b_data_q [DEPTH];
   logic [AW-1:0] a_wptr, a_rptr, b_wptr, b_rptr;
   logic [AW:0]   a_cnt, b_cnt;
   logic          last_grant_b;
   logic          a_push, b_push, grant_a, grant_b;

   function automatic logic [31:0] onehot(input logic [4:0] r);
      onehot = 32'd1 << r;
   endfunction

   // Slot j holds a live entry when its distance from the read pointer is below the count.
   function automatic logic slot_valid(input int j, input logic [AW-1:0] rptr,
                                       input logic [AW:0] cnt);
      logic [AW-1:0] off;
      off = AW'(j) - rptr;
      slot_valid = ({1'b0, off} < cnt);
   endfunction

   assign a_ready = (a_cnt < CNT_FULL);
   assign b_ready = (b_cnt < CNT_FULL);
   // Writes to x0 are handshaken but dropped here.
   assign a_push  = a_valid && a_ready && (a_rd != 5'd0);
   assign b_push  = b_valid && b_ready && (b_rd != 5'd0);
   assign idle    = (a_cnt == '0) && (b_cnt == '0) && !rf_we;

   // Round-robin grant over the two FIFO heads.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if ((a_cnt != '0) && (b_cnt != '0)) begin
         if (last_grant_b) grant_a = 1'b1;
         else              grant_b = 1'b1;
      end else if (a_cnt != '0) begin
         grant_a = 1'b1;
      end else if (b_cnt != '0) begin
         grant_b = 1'b1;
      end else begin
         grant_a = 1'b0;
      end
   end

   // FIFO storage; contents need no reset since counts gate their visibility.
   always_ff @(posedge clk) begin
      if (a_push) begin
         a_rd_q[a_wptr]   <= a_rd;
         a_data_q[a_wptr] <= a_data;
      end
      if (b_push) begin
         b_rd_q[b_wptr]   <= b_rd;
         b_data_q[b_wptr] <= b_data;
      end
   end

   // FIFO pointers and counts.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_wptr <= '0; a_rptr <= '0; a_cnt <= '0;
         b_wptr <= '0; b_rptr <= '0; b_cnt <= '0;
      end else begin
         if (a_push)  a_wptr <= a_wptr + AW'(1);
         if (grant_a) a_rptr <= a_rptr + AW'(1);
         if (b_push)  b_wptr <= b_wptr + AW'(1);
         if (grant_b) b_rptr <= b_rptr + AW'(1);
         a_cnt <= a_cnt + (AW+1)'(a_push) - (AW+1)'(grant_a);
         b_cnt <= b_cnt + (AW+1)'(b_push) - (AW+1)'(grant_b);
      end
   end

   // Registered write stage; rf_rd/rf_din hold when nothing is granted.
   always_ff @(posedge clk) begin
      if (reset) begin
         rf_we        <= 1'b0;
         rf_rd        <= 5'd0;
         rf_din       <= 32'd0;
         last_grant_b <= 1'b1;
      end else if (grant_a) begin
         rf_we        <= 1'b1;
         rf_rd        <= a_rd_q[a_rptr];
         rf_din       <= a_data_q[a_rptr];
         last_grant_b <= 1'b0;
      end else if (grant_b) begin
         rf_we        <= 1'b1;
         rf_rd        <= b_rd_q[b_rptr];
         rf_din       <= b_data_q[b_rptr];
         last_grant_b <= 1'b1;
      end else begin
         rf_we        <= 1'b0;
      end
   end

   // Outstanding-write view over live FIFO slots plus the write stage.
   always_comb begin
      pending_mask = 32'd0;
      for (int j = 0; j < DEPTH; j++) begin
         pending_mask = pending_mask |
                        (slot_valid(j, a_rptr, a_cnt) ? onehot(a_rd_q[j]) : 32'd0) |
                        (slot_valid(j, b_rptr, b_cnt) ? onehot(b_rd_q[j]) : 32'd0);
      end
      pending_mask = pending_mask | (rf_we ? onehot(rf_rd) : 32'd0);
      pending_mask[0] = 1'b0;
   end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a queue-based
// reference model of the two writeback FIFOs and round-robin write stage.
module tb_regfile_wb_arbiter;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        a_valid, b_valid;
   logic        a_ready, b_ready;
   logic [4:0]  a_rd, b_rd;
   logic [31:0] a_data, b_data;
   logic        rf_we;
   logic [4:0]  rf_rd;
   logic [31:0] rf_din;
   logic [31:0] pending_mask;
   logic        idle;

   regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_din(rf_din),
      .pending_mask(pending_mask), .idle(idle)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   ent_t        qa[$];
   ent_t        qb[$];
   bit          m_last_b = 1'b1;
   bit          m_we     = 1'b0;
   logic [4:0]  m_rd     = 5'd0;
   logic [31:0] m_din    = 32'd0;
   int          checks   = 0;
   int          failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] m_pending();
      logic [31:0] pm = 32'd0;
      foreach (qa[i]) pm[qa[i].rd] = 1'b1;
      foreach (qb[i]) pm[qb[i].rd] = 1'b1;
      if (m_we) pm[m_rd] = 1'b1;
      pm[0] = 1'b0;
      return pm;
   endfunction

   task automatic check_outputs();
      check("a_ready", a_ready, 32'(qa.size() < DEPTH));
      check("b_ready", b_ready, 32'(qb.size() < DEPTH));
      check("rf_we", rf_we, 32'(m_we));
      check("rf_rd", rf_rd, 32'(m_rd));
      check("rf_din", rf_din, m_din);
      check("pending_mask", pending_mask, m_pending());
      check("idle", idle, 32'(qa.size() == 0 && qb.size() == 0 && !m_we));
   endtask

   // One clock: check current outputs, drive inputs, advance model across the edge.
   task automatic step(input bit rst, input bit av, input logic [4:0] ard, input logic [31:0] ad,
                       input bit bv, input logic [4:0] brd, input logic [31:0] bd);
      bit a_acc, b_acc, ga, gb;
      ent_t e;
      check_outputs();
      reset = rst; a_valid = av; a_rd = ard; a_data = ad;
      b_valid = bv; b_rd = brd; b_data = bd;
      @(posedge clk);
      if (rst) begin
         qa.delete(); qb.delete();
         m_we = 1'b0; m_rd = 5'd0; m_din = 32'd0; m_last_b = 1'b1;
      end else begin
         a_acc = av && (qa.size() < DEPTH);
         b_acc = bv && (qb.size() < DEPTH);
         ga = (qa.size() > 0) && ((qb.size() == 0) || m_last_b);
         gb = (qb.size() > 0) && ((qa.size() == 0) || !m_last_b);
         if (ga) begin
            e = qa.pop_front(); m_we = 1'b1; m_rd = e.rd; m_din = e.data; m_last_b = 1'b0;
         end else if (gb) begin
            e = qb.pop_front(); m_we = 1'b1; m_rd = e.rd; m_din = e.data; m_last_b = 1'b1;
         end else begin
            m_we = 1'b0;
         end
         if (a_acc && ard != 5'd0) qa.push_back('{rd: ard, data: ad});
         if (b_acc && brd != 5'd0) qb.push_back('{rd: brd, data: bd});
      end
      @(negedge clk);
   endtask

   task automatic idle_step();
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   task automatic reset_step();
      step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   initial begin
      bit          saw_full;
      int          na;
      logic [31:0] exp_rd;
      reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
      a_rd = 5'd0; b_rd = 5'd0; a_data = 32'd0; b_data = 32'd0;
      @(posedge clk);
      @(negedge clk);
      reset_step();

      // 1: single A write, two-edge latency
      step(1'b0, 1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0);
      check("t1_we_early", rf_we, 32'd0);
      check("t1_pend5_q", pending_mask, 32'h20);
      idle_step();
      check("t1_we", rf_we, 32'd1);
      check("t1_rd", rf_rd, 32'd5);
      check("t1_din", rf_din, 32'h11);
      check("t1_pend5_w", pending_mask, 32'h20);
      idle_step();
      check("t1_pend_clear", pending_mask, 32'd0);
      check("t1_idle", idle, 32'd1);

      // 2: both ports push every cycle, grants A,B,A,B after reset
      reset_step();
      for (int k = 0; k < 8; k++) begin
         step(1'b0, 1'b1, 5'(1 + k), 32'hA000 + 32'(k), 1'b1, 5'(9 + k), 32'hB000 + 32'(k));
         if (k >= 1) begin
            exp_rd = (k % 2 == 1) ? 32'(1 + (k - 1) / 2) : 32'(9 + k / 2 - 1);
            check("t2_we", rf_we, 32'd1);
            check("t2_order", rf_rd, exp_rd);
         end
      end
      for (int k = 0; k < 10; k++) idle_step();

      // 3: A fills under contention; held request accepted once space frees
      reset_step();
      saw_full = 1'b0;
      na = 1;
      for (int k = 0; k < 16; k++) begin
         if (qa.size() >= DEPTH) saw_full = 1'b1;
         if (qa.size() < DEPTH) begin
            step(1'b0, 1'b1, 5'(na), 32'hC0 + 32'(na), 1'b1, 5'(20 + k % 8), 32'hD0 + 32'(k));
            na++;
         end else begin
            step(1'b0, 1'b1, 5'(na), 32'hC0 + 32'(na), 1'b1, 5'(20 + k % 8), 32'hD0 + 32'(k));
         end
      end
      check("t3_full_seen", 32'(saw_full), 32'd1);
      for (int k = 0; k < 12; k++) idle_step();

      // 4: write to x0 is swallowed
      reset_step();
      check("t4_b_ready", b_ready, 32'd1);
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
      check("t4_idle", idle, 32'd1);
      idle_step();
      check("t4_we", rf_we, 32'd0);
      check("t4_pend", pending_mask, 32'd0);

      // 5: reset mid-drain discards queued entries
      step(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd14, 32'h44);
      step(1'b0, 1'b1, 5'd4, 32'h34, 1'b1, 5'd15, 32'h45);
      step(1'b0, 1'b1, 5'd6, 32'h36, 1'b0, 5'd0, 32'd0);
      reset_step();
      check("t5_pend", pending_mask, 32'd0);
      check("t5_idle", idle, 32'd1);
      for (int k = 0; k < 4; k++) begin
         idle_step();
         check("t5_no_we", rf_we, 32'd0);
      end

      // 6: pending mask clears bit by bit
      step(1'b0, 1'b1, 5'd7, 32'h77, 1'b1, 5'd12, 32'hCC);
      check("t6_both", pending_mask, 32'h0000_1080);
      idle_step();
      check("t6_a_wr", pending_mask, 32'h0000_1080);
      idle_step();
      check("t6_b_wr", pending_mask, 32'h0000_1000);
      idle_step();
      check("t6_empty", pending_mask, 32'd0);

      // Randomized traffic with occasional reset
      for (int k = 0; k < 600; k++) begin
         step(($urandom_range(0, 99) == 0),
              ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 31)), $urandom(),
              ($urandom_range(0, 99) < 55), 5'($urandom_range(0, 31)), $urandom());
      end
      for (int k = 0; k < 12; k++) idle_step();
      check_outputs();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
